// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: start/serve/over flow, ball budget, per-player scoring, optional win limit.
// Optional pause state is compiled in with `define PONG_PAUSE_EN.

module pong_score_lane #(
  parameter int SCORE_W   = 7,
  parameter int WIN_SCORE = 0
) (
  input  logic               top_clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] score,
  output logic               win_hit
);
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  logic [SCORE_W-1:0] score_nx;

  // Saturating increment; win_hit qualifies the value this lane would take if it scored now.
  assign score_nx = (score == '1) ? score : score + 1'b1;
  assign win_hit  = (WIN_SCORE != 0) && (score_nx == WIN_V);

  always_ff @(posedge top_clk or posedge reset) begin
    if (reset)    score <= '0;
    else if (clr) score <= '0;
    else if (inc) score <= score_nx;
  end
endmodule

module pong_match_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int BALLS        = 3,
  parameter int DELAY_FRAMES = 120,
  parameter int SCORE_W      = 7,
  parameter int WIN_SCORE    = 0
) (
  input  logic                           top_clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [NUM_PLAYERS-1:0]         start_req,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         miss,
  input  logic                           pause_req,
  output logic [2:0]                     state,
  output logic                           gra_still,
  output logic [NUM_PLAYERS-1:0]         d_inc,
  output logic                           d_clr,
  output logic [3:0]                     balls_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [1:0]                     winner,
  output logic                           win_valid
);
  localparam logic [2:0] S_NEWGAME = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_NEWBALL = 3'd2;
  localparam logic [2:0] S_OVER    = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  logic [2:0]             state_nx;
  logic [NUM_PLAYERS-1:0] start_q;
  logic                   press;
  logic [9:0]             timer;
  logic                   timer_up;
  logic                   miss_any;
  logic                   play_hit;
  logic                   win_now;
  logic [1:0]             hit_idx;
  logic [NUM_PLAYERS-1:0] lane_inc;
  logic [NUM_PLAYERS-1:0] lane_win;
  logic                   pause_edge;

  assign press    = |(start_req & ~start_q);
  assign timer_up = (timer == '0);
  assign miss_any = |miss;
  assign play_hit = (state == S_PLAY) && !miss_any && (|hit);
  assign win_now  = |(lane_inc & lane_win);

`ifdef PONG_PAUSE_EN
  logic pause_q;
  assign pause_edge = pause_req & ~pause_q;
  always_ff @(posedge top_clk or posedge reset) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_req;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_req;
  assign pause_edge   = 1'b0;
`endif

  // Scanning downward leaves the lowest set hit bit as the winner.
  always_comb begin
    hit_idx = 2'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (hit[i]) hit_idx = 2'(i);
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    assign lane_inc[i] = play_hit && (hit_idx == 2'(i));
    pong_score_lane #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_lane (
      .top_clk (top_clk),
      .reset   (reset),
      .clr     (state == S_NEWGAME),
      .inc     (lane_inc[i]),
      .score   (score[i*SCORE_W +: SCORE_W]),
      .win_hit (lane_win[i])
    );
  end

  always_ff @(posedge top_clk or posedge reset) begin
    if (reset) state <= S_NEWGAME;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_NEWGAME: if (press) state_nx = S_PLAY;
      S_PLAY: begin
        if (miss_any)        state_nx = (balls_left == 4'd1) ? S_OVER : S_NEWBALL;
        else if (win_now)    state_nx = S_OVER;
        else if (pause_edge) state_nx = S_PAUSE;
      end
      S_NEWBALL: if (timer_up && press) state_nx = S_PLAY;
      S_OVER:    if (timer_up) state_nx = S_NEWGAME;
      S_PAUSE:   if (pause_edge) state_nx = S_PLAY;
      default:   state_nx = S_NEWGAME;
    endcase
  end

  always_comb begin
    gra_still = (state != S_PLAY);
    d_clr     = (state == S_NEWGAME);
  end

  // Timer load on miss/win takes precedence over a coincident frame tick; PAUSE freezes it.
  always_ff @(posedge top_clk or posedge reset) begin
    if (reset) begin
      start_q    <= '0;
      d_inc      <= '0;
      balls_left <= 4'(BALLS);
      timer      <= '0;
      winner     <= '0;
      win_valid  <= 1'b0;
    end else begin
      start_q <= start_req;
      d_inc   <= lane_inc;
      if (state == S_NEWGAME) begin
        balls_left <= 4'(BALLS);
        winner     <= '0;
        win_valid  <= 1'b0;
      end
      if (state == S_PLAY && miss_any) begin
        balls_left <= balls_left - 4'd1;
        timer      <= 10'(DELAY_FRAMES);
      end else if (win_now) begin
        winner    <= hit_idx;
        win_valid <= 1'b1;
        timer     <= 10'(DELAY_FRAMES);
      end else if (frame_tick && !timer_up && state != S_PAUSE) begin
        timer <= timer - 10'd1;
      end
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl: 2 players, 3 balls, 120-frame delay, win at 5.
module tb_pong_match_ctrl;
  logic        top_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [1:0]  start_req = '0, hit = '0, miss = '0;
  logic        pause_req = 1'b0;
  logic [2:0]  state;
  logic        gra_still, d_clr, win_valid;
  logic [1:0]  d_inc, winner;
  logic [3:0]  balls_left;
  logic [13:0] score;

  int n_cmp = 0, n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;
  logic [6:0] m_s0 = '0, m_s1 = '0;

  always #5 top_clk = ~top_clk;

  pong_match_ctrl #(.NUM_PLAYERS(2), .BALLS(3), .DELAY_FRAMES(120), .SCORE_W(7), .WIN_SCORE(5)) dut (
    .top_clk(top_clk), .reset(reset), .frame_tick(frame_tick), .start_req(start_req),
    .hit(hit), .miss(miss), .pause_req(pause_req), .state(state), .gra_still(gra_still),
    .d_inc(d_inc), .d_clr(d_clr), .balls_left(balls_left), .score(score),
    .winner(winner), .win_valid(win_valid));

  // Drives one cycle of hit/miss and queues the d_inc the bench expects one clock later.
  task automatic play_cycle(input logic [1:0] h, input logic [1:0] m, input bit live);
    logic [1:0] x;
    x = 2'b00;
    if (live && m == 2'b00) begin
      if (h[0])      begin x = 2'b01; m_s0 = m_s0 + 7'd1; end
      else if (h[1]) begin x = 2'b10; m_s1 = m_s1 + 7'd1; end
    end
    exp_q.push_back(x);
    hit = h; miss = m;
    @(negedge top_clk);
    hit = '0; miss = '0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; @(negedge top_clk);
      frame_tick = 1'b0; @(negedge top_clk);
    end
  endtask

  task automatic press();
    start_req = 2'b01; @(negedge top_clk);
    start_req = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge top_clk);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state); end
    n_cmp++; if ({gra_still, d_clr} !== 2'b11) begin n_err++; $display("FAIL rst_decode got=%b exp=11", {gra_still, d_clr}); end
    n_cmp++; if (balls_left !== 4'd3) begin n_err++; $display("FAIL rst_balls got=%0d exp=3", balls_left); end
    n_cmp++; if ({score, d_inc, winner, win_valid} !== '0) begin n_err++; $display("FAIL rst_regs got=%h exp=0", {score, d_inc, winner, win_valid}); end
    reset = 1'b0;
    @(negedge top_clk);
  endtask

  task automatic test_start_edge();
    int trans;
    logic [2:0] prev;
    trans = 0;
    start_req = 2'b01;
    for (int i = 0; i < 50; i++) begin
      prev = state;
      @(negedge top_clk);
      if (prev == 3'd0 && state == 3'd1) trans++;
    end
    start_req = 2'b00;
    n_cmp++; if (trans != 1) begin n_err++; $display("FAIL start_transitions got=%0d exp=1", trans); end
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL start_state got=%0d exp=1", state); end
    n_cmp++; if (balls_left !== 4'd3) begin n_err++; $display("FAIL start_balls got=%0d exp=3", balls_left); end
    n_cmp++; if ({gra_still, d_clr} !== 2'b00) begin n_err++; $display("FAIL start_decode got=%b exp=00", {gra_still, d_clr}); end
  endtask

  task automatic test_hit_priority();
    play_cycle(2'b11, 2'b00, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL hit11_dinc got=%b exp=%b", d_inc, e); end
    n_cmp++; if (score !== {m_s1, m_s0}) begin n_err++; $display("FAIL hit11_score got=%h exp=%h", score, {m_s1, m_s0}); end
    @(negedge top_clk);
    n_cmp++; if (d_inc !== 2'b00) begin n_err++; $display("FAIL hit11_pulse_width got=%b exp=00", d_inc); end
    play_cycle(2'b10, 2'b00, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL hit10_dinc got=%b exp=%b", d_inc, e); end
    n_cmp++; if (score !== {m_s1, m_s0}) begin n_err++; $display("FAIL hit10_score got=%h exp=%h", score, {m_s1, m_s0}); end
  endtask

  task automatic test_miss_and_hit();
    play_cycle(2'b10, 2'b01, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL misshit_dinc got=%b exp=%b", d_inc, e); end
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL misshit_state got=%0d exp=2", state); end
    n_cmp++; if (balls_left !== 4'd2) begin n_err++; $display("FAIL misshit_balls got=%0d exp=2", balls_left); end
    n_cmp++; if (score !== {m_s1, m_s0}) begin n_err++; $display("FAIL misshit_score got=%h exp=%h", score, {m_s1, m_s0}); end
  endtask

  task automatic test_newball_delay();
    frames(60);
    press();
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL early_press got=%0d exp=2", state); end
    frames(60);
    press();
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL late_press got=%0d exp=1", state); end
  endtask

  task automatic test_win();
    for (int i = 0; i < 4; i++) begin
      play_cycle(2'b10, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL win_hit%0d_dinc got=%b exp=%b", i, d_inc, e); end
    end
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL win_state got=%0d exp=3", state); end
    n_cmp++; if ({winner, win_valid} !== 3'b011) begin n_err++; $display("FAIL win_report got=%b exp=011", {winner, win_valid}); end
    n_cmp++; if (score !== {7'd5, 7'd1}) begin n_err++; $display("FAIL win_score got=%h exp=%h", score, {7'd5, 7'd1}); end
    play_cycle(2'b01, 2'b00, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL over_hit_dinc got=%b exp=%b", d_inc, e); end
    frames(120);
    n_cmp++; if ({state, d_clr} !== 4'b0001) begin n_err++; $display("FAIL win_to_newgame got=%b exp=0001", {state, d_clr}); end
    @(negedge top_clk);
    m_s0 = '0; m_s1 = '0;
    n_cmp++; if ({win_valid, winner, score} !== '0) begin n_err++; $display("FAIL newgame_clear got=%h exp=0", {win_valid, winner, score}); end
    n_cmp++; if (balls_left !== 4'd3) begin n_err++; $display("FAIL newgame_balls got=%0d exp=3", balls_left); end
  endtask

  task automatic test_ball_budget();
    press();
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL budget_start got=%0d exp=1", state); end
    for (int k = 0; k < 3; k++) begin
      play_cycle(2'b00, 2'b01, 1'b1);
      e = exp_q.pop_front();
      n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL miss%0d_dinc got=%b exp=%b", k, d_inc, e); end
      n_cmp++; if (state !== ((k < 2) ? 3'd2 : 3'd3)) begin n_err++; $display("FAIL miss%0d_state got=%0d exp=%0d", k, state, (k < 2) ? 2 : 3); end
      n_cmp++; if (balls_left !== 4'(2 - k)) begin n_err++; $display("FAIL miss%0d_balls got=%0d exp=%0d", k, balls_left, 2 - k); end
      if (k < 2) begin
        frames(120);
        press();
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL serve%0d got=%0d exp=1", k, state); end
      end
    end
    n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL budget_winvalid got=%b exp=0", win_valid); end
    frames(119);
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL over_hold got=%0d exp=3", state); end
    frames(1);
    n_cmp++; if ({state, d_clr} !== 4'b0001) begin n_err++; $display("FAIL over_expire got=%b exp=0001", {state, d_clr}); end
  endtask

  task automatic test_pause();
    press();
    pause_req = 1'b1; @(negedge top_clk);
    pause_req = 1'b0; @(negedge top_clk);
`ifdef PONG_PAUSE_EN
    n_cmp++; if ({state, gra_still} !== 4'b1001) begin n_err++; $display("FAIL pause_enter got=%b exp=1001", {state, gra_still}); end
    play_cycle(2'b01, 2'b00, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL pause_hit_dinc got=%b exp=%b", d_inc, e); end
    n_cmp++; if (score !== {m_s1, m_s0}) begin n_err++; $display("FAIL pause_score got=%h exp=%h", score, {m_s1, m_s0}); end
    play_cycle(2'b00, 2'b01, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if ({state, balls_left} !== {3'd4, 4'd3}) begin n_err++; $display("FAIL pause_miss got=%b exp=%b", {state, balls_left}, {3'd4, 4'd3}); end
    pause_req = 1'b1; @(negedge top_clk);
    pause_req = 1'b0; @(negedge top_clk);
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL pause_exit got=%0d exp=1", state); end
    pause_req = 1'b1; @(negedge top_clk);
    pause_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL pause_reset got=%0d exp=0", state); end
    @(negedge top_clk);
    reset = 1'b0;
    @(negedge top_clk);
    press();
`else
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL nopause_state got=%0d exp=1", state); end
    play_cycle(2'b01, 2'b00, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL nopause_dinc got=%b exp=%b", d_inc, e); end
`endif
  endtask

  task automatic test_reset_midgame();
    hit = 2'b01;
    @(negedge top_clk);
    hit = 2'b00;
    exp_q.push_back(2'b00);
    #1 reset = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_cmp++; if (d_inc !== e) begin n_err++; $display("FAIL midreset_dinc got=%b exp=%b", d_inc, e); end
    n_cmp++; if ({state, balls_left} !== {3'd0, 4'd3}) begin n_err++; $display("FAIL midreset_state got=%b exp=%b", {state, balls_left}, {3'd0, 4'd3}); end
    @(negedge top_clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_edge();
    test_hit_priority();
    test_miss_and_hit();
    test_newball_delay();
    test_win();
    test_ball_budget();
    test_pause();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
